// File: rtl/reg_file.sv
// General-purpose register file for the decode stage: two combinational read
// ports, one synchronous write port, register 0 hard-wired to zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              regwrite,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;

  // An X or low regwrite never qualifies a write, so undriven inputs cannot
  // corrupt storage.
  assign wr_en = regwrite && (rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd] = writedata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: same-cycle writes become visible only after the edge.
  assign A = (rs == '0) ? '0 : regs_q[rs];
  assign B = (rt == '0) ? '0 : regs_q[rt];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs, rt, rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic [31:0] A, B;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .writedata (writedata),
    .regwrite  (regwrite),
    .A         (A),
    .B         (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rd        = addr;
    writedata = data;
    regwrite  = 1'b1;
    @(posedge clk);
    #1;
    regwrite  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    regwrite  = 1'b0;
    rs        = 5'd7;
    rt        = 5'd0;
    rd        = 'x;
    writedata = 'x;
    repeat (2) @(posedge clk);
    #1;
    check("reset_A", A, 32'h0);
    check("reset_B", B, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Undriven rd/writedata with regwrite low must leave storage intact
    @(posedge clk);
    #1;
    check("x_inputs_no_write", A, 32'h0);

    // Asynchronous reset mid-cycle
    wr(5'd7, 32'hDEADBEEF);
    rs = 5'd7;
    #1;
    check("pre_reset_r7", A, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_r7", A, 32'h0);
    rd = 5'd7; writedata = 32'h1234_5678; regwrite = 1'b1;
    @(posedge clk);
    #1;
    check("write_during_reset", A, 32'h0);
    regwrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // regwrite low across an edge
    @(negedge clk);
    rs = 5'd0; rt = 5'd1; rd = 5'd4; writedata = 32'd5; regwrite = 1'b0;
    @(posedge clk);
    #1;
    check("disabled_A", A, 32'h0);
    check("disabled_B", B, 32'h0);
    rs = 5'd4;
    #1;
    check("disabled_r4", A, 32'h0);

    // Basic write, then stability over later edges
    wr(5'd4, 32'd5);
    rs = 5'd4; rt = 5'd1;
    #1;
    check("basic_A", A, 32'd5);
    check("basic_B", B, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("basic_stable", A, 32'd5);

    // Register 0 is write-protected
    wr(5'd0, 32'hFFFFFFFF);
    rs = 5'd0; rt = 5'd0;
    #1;
    check("r0_A", A, 32'h0);
    check("r0_B", B, 32'h0);

    // Read-during-write: old value before edge, new value right after
    wr(5'd9, 32'h11);
    @(negedge clk);
    rs = 5'd9; rd = 5'd9; writedata = 32'h22; regwrite = 1'b1;
    #1;
    check("rdw_before", A, 32'h11);
    @(posedge clk);
    #1;
    check("rdw_after", A, 32'h22);
    regwrite = 1'b0;

    // Same register on both ports
    rs = 5'd9; rt = 5'd9;
    #1;
    check("rs_eq_rt_A", A, 32'h22);
    check("rs_eq_rt_B", B, 32'h22);

    // Full sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i);
      rt = 5'(31 - i);
      #1;
      check($sformatf("sweep_A_r%0d", i), A, 32'(i) * 32'h01010101);
      check($sformatf("sweep_B_r%0d", 31 - i), B, 32'(31 - i) * 32'h01010101);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
